// File: rtl/soc_system_led_sequencer.sv
// soc_system_led_sequencer: chase/static LED sequencer that ORs in string hits and drives timed PIO writes
module soc_system_led_sequencer #(
  parameter int LED_WIDTH = 10,
  parameter int PERIOD_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [LED_WIDTH-1:0] hit,
  output logic [1:0]           pio_address,
  output logic                 pio_chipselect,
  output logic                 pio_write_n,
  output logic [31:0]          pio_writedata
);
  localparam int PW = LED_WIDTH > 1 ? $clog2(LED_WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, WRITE, BLANK} state_t;
  state_t                  state, state_nx;
  logic [1:0]              ctrl;
  logic [PERIOD_WIDTH-1:0] period, count, count_nx, term;
  logic [LED_WIDTH-1:0]    stat, hit_latch, latch_nx, last, last_nx, value;
  logic [PW-1:0]           pos, pos_nx, pos_adv;
  logic                    cfg_we, go_write, go_blank;
  assign cfg_we      = chipselect && !write_n;
  assign pio_address = 2'b00;
  assign term        = (period == '0) ? '0 : period - 1'b1;
  assign pos_adv     = (pos == PW'(LED_WIDTH - 1)) ? '0 : pos + 1'b1;
  // Config read mux; STATUS mirrors the last value sent to the LEDs
  always_comb begin
    readdata = (address == 2'd0) ? {30'b0, ctrl} :
               (address == 2'd1) ? 32'(period) :
               (address == 2'd2) ? 32'(stat) : 32'(last);
  end
  // Config register writes; STATUS is read-only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl   <= '0;
      period <= '0;
      stat   <= '0;
    end else if (cfg_we) begin
      if (address == 2'd0) ctrl <= writedata[1:0];
      if (address == 2'd1) period <= writedata[PERIOD_WIDTH-1:0];
      if (address == 2'd2) stat <= writedata[LED_WIDTH-1:0];
    end
  end
  // Next state; PIO data is captured on the edge entering WRITE/BLANK so the strobe is visible during that state
  always_comb begin
    state_nx = state;
    count_nx = count;
    pos_nx   = pos;
    case (state)
      IDLE: begin
        count_nx = '0;
        state_nx = ctrl[0] ? WRITE : IDLE;
      end
      RUN: begin
        if (!ctrl[0]) state_nx = BLANK;
        else if (count >= term) begin
          count_nx = '0;
          pos_nx   = ctrl[1] ? pos : pos_adv;
          state_nx = WRITE;
        end else count_nx = count + 1'b1;
      end
      WRITE: state_nx = ctrl[0] ? RUN : BLANK;
      default: state_nx = IDLE;
    endcase
    go_write = state_nx == WRITE;
    go_blank = state_nx == BLANK;
    value    = (ctrl[1] ? stat : LED_WIDTH'(1) << pos_nx) | hit_latch;
    latch_nx = go_write ? hit : hit_latch | hit;
    last_nx  = go_write ? value : go_blank ? '0 : last;
  end
  // State, counters, hit latch and registered PIO outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      count          <= '0;
      pos            <= '0;
      hit_latch      <= '0;
      last           <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
    end else begin
      state          <= state_nx;
      count          <= count_nx;
      pos            <= pos_nx;
      hit_latch      <= latch_nx;
      last           <= last_nx;
      pio_chipselect <= go_write || go_blank;
      pio_write_n    <= !(go_write || go_blank);
      pio_writedata  <= go_write ? 32'(value) : go_blank ? '0 : pio_writedata;
    end
  end
endmodule

// File: tb/tb_soc_system_led_sequencer.sv
// tb_soc_system_led_sequencer: directed stimulus with a scoreboard queue of expected PIO writes
module tb_soc_system_led_sequencer;
  logic        clk = 0, reset_n = 0;
  logic [1:0]  address = 0;
  logic        chipselect = 0, write_n = 1;
  logic [31:0] writedata = 0, readdata;
  logic [9:0]  hit = 0;
  logic [1:0]  pio_address;
  logic        pio_chipselect, pio_write_n;
  logic [31:0] pio_writedata;
  typedef struct { logic [31:0] v; int gap; } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, passes = 0, cyc = 0, last_cyc = 0;

  soc_system_led_sequencer dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .hit(hit),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every PIO write pops one expectation (value and spacing)
  always @(negedge clk) begin
    if (pio_chipselect && !pio_write_n) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got 0x%0h with no write expected", pio_writedata);
      end else begin
        e = q.pop_front();
        chk("pio_data", pio_writedata, e.v);
        chk("pio_addr", 32'(pio_address), 0);
        if (e.gap > 0) chk("pio_gap", 32'(cyc - last_cyc), 32'(e.gap));
      end
      last_cyc = cyc;
    end
  end

  task automatic push(input logic [31:0] v, input int gap);
    q.push_back(exp_t'{v, gap});
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1; write_n = 0; writedata = d;
    @(negedge clk);
    chipselect = 0; write_n = 1;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
    #1 chk(name, readdata, exp);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin @(posedge clk); n++; end
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d writes pending after %0d cycles", q.size(), budget);
      q.delete();
    end
  endtask

  task automatic wait_write(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(pio_chipselect && !pio_write_n) && n < budget);
    if (!(pio_chipselect && !pio_write_n)) begin
      checks++;
      $display("FAIL wait_write: no PIO write within %0d cycles", budget);
    end
  endtask

  task automatic stop_run();
    push(0, 0);
    cfg_wr(0, 0);
    drain(20);
    repeat (20) @(posedge clk);
    rd("status_after_stop", 3, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(pio_chipselect), 0);
    chk("rst_wn", 32'(pio_write_n), 1);
    chk("rst_wd", pio_writedata, 0);
    reset_n = 1;
    for (int i = 0; i < 4; i++) rd("rst_read", 2'(i), 0);

    // Chase, PERIOD=4: one-hot walk with wrap, writes 5 clocks apart
    cfg_wr(1, 4);
    rd("period_rb", 1, 4);
    push(32'h001, 0);
    for (int i = 1; i < 10; i++) push(32'h1 << i, 5);
    push(32'h001, 5);
    cfg_wr(0, 1);
    rd("ctrl_rb", 0, 1);
    drain(100);
    stop_run();

    // Static 0x155, PERIOD=2: writes every 3 clocks, STATUS mirrors value
    cfg_wr(2, 32'h155);
    cfg_wr(1, 2);
    push(32'h155, 0); push(32'h155, 3); push(32'h155, 3);
    cfg_wr(0, 3);
    wait_write(20);
    rd("status_static", 3, 32'h155);
    rd("static_rb", 2, 32'h155);
    drain(40);
    stop_run();

    // Hit overlay on static 0: mid-step hit, then hit coincident with WRITE
    cfg_wr(2, 0);
    cfg_wr(1, 4);
    push(0, 0);
    cfg_wr(0, 3);
    drain(20);
    @(negedge clk);
    hit = 10'h008;
    push(32'h008, 5); push(0, 5);
    @(negedge clk);
    hit = 0;
    wait_write(20);
    wait_write(20);
    hit = 10'h040;
    push(32'h040, 5); push(0, 5);
    @(negedge clk);
    hit = 0;
    drain(40);
    stop_run();

    // PERIOD=0 chase: writes every 2 clocks, then async reset during a WRITE
    cfg_wr(1, 0);
    push(32'h001, 0); push(32'h002, 2); push(32'h004, 2); push(32'h008, 2);
    cfg_wr(0, 1);
    for (int i = 0; i < 4; i++) wait_write(20);
    #2 reset_n = 0;
    #1;
    chk("async_cs", 32'(pio_chipselect), 0);
    chk("async_wn", 32'(pio_write_n), 1);
    chk("async_wd", pio_writedata, 0);
    chk("queue_empty", 32'(q.size()), 0);
    @(negedge clk);
    reset_n = 1;
    rd("post_rst_ctrl", 0, 0);
    rd("post_rst_status", 3, 0);
    repeat (10) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
